// File: rtl/logic_seq_pkg.sv
// Shared encodings for the logic-unit sequencer: command ops, one-hot selects,
// FSM states and the op-to-select mapping.
package logic_seq_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] ONEHOT_AND  = 3'b001;
    localparam logic [2:0] ONEHOT_OR   = 3'b010;
    localparam logic [2:0] ONEHOT_XOR  = 3'b100;
    localparam logic [2:0] ONEHOT_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seqState_t;

    // The reserved op maps to no select, so the logic unit never sees a multi-hot code.
    function automatic logic [2:0] opToOneHot(input logic [1:0] op);
        logic [2:0] oh;
        case (op)
            OP_AND:  oh = ONEHOT_AND;
            OP_OR:   oh = ONEHOT_OR;
            OP_XOR:  oh = ONEHOT_XOR;
            default: oh = ONEHOT_NONE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/logic_op_sequencer.sv
// Initiator-side controller for the one-hot-opcode logic unit.
// Define LOGIC_SEQ_ONEHOT_CHECK_EN to capture only the selected result and flag stray results.
//
// state | meaning
// IDLE  | waiting for a command (cmdReady=1)
// ISSUE | operands/opCode driven to the logic unit, result settles
// RESP  | result held on rspData/rspErr until consumed
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               cmdValid,
    output logic               cmdReady,
    input  logic [1:0]         cmdOp,
    input  logic [WIDTH-1:0]   cmdA,
    input  logic [WIDTH-1:0]   cmdB,
    output logic [2:0]         luOpCode,
    output logic [WIDTH-1:0]   luA,
    output logic [WIDTH-1:0]   luB,
    input  logic [WIDTH-1:0]   luResultA,
    input  logic [WIDTH-1:0]   luResultO,
    input  logic [WIDTH-1:0]   luResultX,
    output logic               rspValid,
    input  logic               rspReady,
    output logic [WIDTH-1:0]   rspData,
    output logic               rspErr,
    output logic [OPCNT_W-1:0] opCount
);

    seqState_t state, stateNext;
    logic [WIDTH-1:0] issueData;
    logic             issueErr;

    assign cmdReady = (state == IDLE);
    assign rspValid = (state == RESP);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (cmdValid) stateNext = (cmdOp == OP_RSVD) ? RESP : ISSUE;
            end
            ISSUE:   stateNext = RESP;
            RESP: begin
                if (rspReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef LOGIC_SEQ_ONEHOT_CHECK_EN
    // A correct logic unit gates every non-selected bus to zero.
    always_comb begin
        issueData = '0;
        issueErr  = 1'b0;
        case (luOpCode)
            ONEHOT_AND: begin
                issueData = luResultA;
                issueErr  = (luResultO != '0) || (luResultX != '0);
            end
            ONEHOT_OR: begin
                issueData = luResultO;
                issueErr  = (luResultA != '0) || (luResultX != '0);
            end
            ONEHOT_XOR: begin
                issueData = luResultX;
                issueErr  = (luResultA != '0) || (luResultO != '0);
            end
            default: begin
                issueData = '0;
                issueErr  = 1'b0;
            end
        endcase
    end
`else
    always_comb begin
        issueData = luResultA | luResultO | luResultX;
        issueErr  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            luOpCode <= ONEHOT_NONE;
            luA      <= '0;
            luB      <= '0;
            rspData  <= '0;
            rspErr   <= 1'b0;
            opCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid) begin
                        luA      <= cmdA;
                        luB      <= cmdB;
                        luOpCode <= opToOneHot(cmdOp);
                        if (cmdOp == OP_RSVD) begin
                            rspData <= '0;
                            rspErr  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    rspData <= issueData;
                    rspErr  <= issueErr;
                end
                RESP: begin
                    if (rspReady) begin
                        luOpCode <= ONEHOT_NONE;
                        if (!rspErr) opCount <= opCount + OPCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer with a behavioural logic unit and a response scoreboard.
// Honours LOGIC_SEQ_ONEHOT_CHECK_EN for the stray-result injection step.
module tb_logic_op_sequencer;
    localparam int WIDTH   = 4;
    localparam int OPCNT_W = 8;

    logic               clk = 1'b0;
    logic               rstN = 1'b0;
    logic               cmdValid = 1'b0;
    logic               cmdReady;
    logic [1:0]         cmdOp = 2'b00;
    logic [WIDTH-1:0]   cmdA = '0;
    logic [WIDTH-1:0]   cmdB = '0;
    logic [2:0]         luOpCode;
    logic [WIDTH-1:0]   luA, luB;
    logic [WIDTH-1:0]   luResultA, luResultO, luResultX;
    logic               rspValid;
    logic               rspReady = 1'b0;
    logic [WIDTH-1:0]   rspData;
    logic               rspErr;
    logic [OPCNT_W-1:0] opCount;
    logic [WIDTH-1:0]   xInject = '0;

    int nAsserts = 0;
    int nFails   = 0;
    logic [OPCNT_W-1:0] expCount = '0;
    logic [WIDTH:0]     sbQ[$];   // {err, data}

    always #5 clk = ~clk;

    // Behavioural gated logic unit; xInject models a faulty XOR output.
    assign luResultA = luOpCode[0] ? (luA & luB) : '0;
    assign luResultO = luOpCode[1] ? (luA | luB) : '0;
    assign luResultX = (luOpCode[2] ? (luA ^ luB) : '0) | xInject;

    logic_op_sequencer #(.WIDTH(WIDTH), .OPCNT_W(OPCNT_W)) dut (
        .clk(clk), .rstN(rstN),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
        .luOpCode(luOpCode), .luA(luA), .luB(luB),
        .luResultA(luResultA), .luResultO(luResultO), .luResultX(luResultX),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
        .opCount(opCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command, waits (bounded) for acceptance, and pushes the expected response.
    task automatic sendCmd(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic injectErr);
        logic [WIDTH-1:0] d;
        logic e;
        int budget;
        case (op)
            2'b00:   d = a & b;
            2'b01:   d = a | b;
            2'b10:   d = a ^ b;
            default: d = '0;
        endcase
        e = (op == 2'b11) || injectErr;
        cmdOp = op; cmdA = a; cmdB = b; cmdValid = 1'b1;
        budget = 0;
        while (!cmdReady && budget < 20) begin
            tick();
            budget++;
        end
        check("cmd_accept_timeout", 32'(cmdReady), 32'd1);
        sbQ.push_back({e, d});
        tick();
        cmdValid = 1'b0;
    endtask

    // Consumes one response after stallCycles of backpressure, checking stability.
    task automatic recvRsp(input int stallCycles);
        logic [WIDTH-1:0]   d0;
        logic               e0;
        logic [OPCNT_W-1:0] c0;
        logic [WIDTH:0]     exp;
        check("rsp_valid", 32'(rspValid), 32'd1);
        d0 = rspData; e0 = rspErr; c0 = opCount;
        rspReady = 1'b0;
        for (int i = 0; i < stallCycles; i++) begin
            tick();
            check("hold_valid", 32'(rspValid), 32'd1);
            check("hold_data", 32'(rspData), 32'(d0));
            check("hold_cmdready", 32'(cmdReady), 32'd0);
            check("hold_count", 32'(opCount), 32'(c0));
        end
        nAsserts++;
        assert (sbQ.size() > 0) else begin
            nFails++;
            $error("FAIL sb_empty: observed %0d expected >0", sbQ.size());
        end
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        check("rsp_data", 32'(rspData), 32'(exp[WIDTH-1:0]));
        check("rsp_err", 32'(rspErr), 32'(exp[WIDTH]));
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        if (!exp[WIDTH]) expCount = expCount + OPCNT_W'(1);
        check("op_count", 32'(opCount), 32'(expCount));
        check("post_rsp_valid", 32'(rspValid), 32'd0);
        check("post_lu_opcode", 32'(luOpCode), 32'd0);
        check("post_cmd_ready", 32'(cmdReady), 32'd1);
    endtask

    initial begin
        // Power-on reset
        #2;
        check("rst_valid", 32'(rspValid), 32'd0);
        check("rst_opcode", 32'(luOpCode), 32'd0);
        check("rst_count", 32'(opCount), 32'd0);
        check("rst_data", 32'(rspData), 32'd0);
        tick();
        rstN = 1'b1;
        tick();
        check("rst_cmdready", 32'(cmdReady), 32'd1);

        // AND: C & A = 8, one-hot 001 during ISSUE, valid after second edge
        sendCmd(2'b00, 4'hC, 4'hA, 1'b0);
        check("and_issue_opcode", 32'(luOpCode), 32'b001);
        check("and_issue_valid", 32'(rspValid), 32'd0);
        check("and_issue_cmdready", 32'(cmdReady), 32'd0);
        tick();
        recvRsp(0);

        // XOR with 4 cycles of backpressure: F ^ 5 = A
        sendCmd(2'b10, 4'hF, 4'h5, 1'b0);
        check("xor_issue_opcode", 32'(luOpCode), 32'b100);
        tick();
        recvRsp(4);

        // Illegal op: response right after accept, no select driven
        sendCmd(2'b11, 4'h7, 4'h3, 1'b0);
        check("ill_valid", 32'(rspValid), 32'd1);
        check("ill_opcode", 32'(luOpCode), 32'd0);
        recvRsp(1);

        // Dropped offer while not ready latches nothing
        sendCmd(2'b01, 4'h1, 4'h2, 1'b0);
        cmdValid = 1'b1; cmdOp = 2'b10; cmdA = 4'hE; cmdB = 4'hE;
        tick();
        cmdValid = 1'b0;
        check("drop_luA", 32'(luA), 32'h1);
        recvRsp(0);

        // 256 OR ops: opCount wraps FF -> 00 along the way
        for (int i = 0; i < 256; i++) begin
            sendCmd(2'b01, 4'h3, 4'h4, 1'b0);
            check("or_issue_opcode", 32'(luOpCode), 32'b010);
            tick();
            recvRsp(0);
        end

        // Asynchronous reset while a response is pending
        sendCmd(2'b00, 4'hF, 4'hF, 1'b0);
        tick();
        check("pre_rst_valid", 32'(rspValid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        check("arst_valid", 32'(rspValid), 32'd0);
        check("arst_opcode", 32'(luOpCode), 32'd0);
        check("arst_count", 32'(opCount), 32'd0);
        sbQ.delete();
        expCount = '0;
        tick();
        rstN = 1'b1;
        tick();
        check("arst_cmdready", 32'(cmdReady), 32'd1);

`ifdef LOGIC_SEQ_ONEHOT_CHECK_EN
        // Stray XOR output during an AND op must be flagged, data is the AND result only
        xInject = 4'h1;
        sendCmd(2'b00, 4'hC, 4'hA, 1'b1);
        tick();
        recvRsp(0);
        xInject = '0;
`endif

        // Clean op after reset
        sendCmd(2'b01, 4'h8, 4'h1, 1'b0);
        tick();
        recvRsp(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
Initiator-side controller for the 4-bit one-hot-opcode logic unit. Accepts operation commands over a valid/ready handshake, drives one-hot opCode and the A/B operands into the logic unit, and captures the selected result. Returns the result, with an error flag, over a second valid/ready handshake. Sits between the instruction/control path and a logic-unit instance, both instantiated at the same parent level.

Parameters:
WIDTH, 4, operand/result width; must equal the logic unit's operand width
OPCNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous, active-low reset
cmdValid  input  1  command offered
cmdReady  output  1  sequencer can accept a command
cmdOp  input  2  00 AND, 01 OR, 10 XOR, 11 reserved/illegal
cmdA  input  WIDTH  operand A
cmdB  input  WIDTH  operand B
luOpCode  output  3  one-hot select to logic unit: bit0 AND, bit1 OR, bit2 XOR
luA  output  WIDTH  registered operand A to logic unit
luB  output  WIDTH  registered operand B to logic unit
luResultA  input  WIDTH  gated AND result from logic unit
luResultO  input  WIDTH  gated OR result from logic unit
luResultX  input  WIDTH  gated XOR result from logic unit
rspValid  output  1  response available
rspReady  input  1  consumer accepts response
rspData  output  WIDTH  captured result
rspErr  output  1  illegal op, or check failure when the optional feature is enabled
opCount  output  OPCNT_W  count of successful (rspErr=0) responses accepted

Behaviour:
- Reset (rstN low, asynchronous): state IDLE; luOpCode=000, luA=luB=0, rspValid=0, rspData=0, rspErr=0, opCount=0. cmdReady=1 once rstN is high. An in-flight command or response is discarded; there is no replay.
- FSM states: IDLE, ISSUE, RESP. cmdReady=1 only in IDLE. rspValid=1 only in RESP.
- IDLE:
  - Command transfers on a clock edge with cmdValid and cmdReady both high. luA/luB load cmdA/cmdB at that edge.
  - cmdOp 00/01/10: luOpCode loads 001/010/100; next state ISSUE.
  - cmdOp 11: luOpCode stays 000; rspData loads 0; rspErr loads 1; next state RESP directly.
- ISSUE: lasts exactly one cycle; logic-unit outputs settle combinationally.
  - At the end of the cycle: rspData <= luResultA | luResultO | luResultX; rspErr <= 0; next state RESP.
- RESP:
  - rspValid=1. rspData and rspErr are held stable until the response transfers.
  - Transfer edge (rspValid & rspReady): luOpCode <= 000; rspValid drops; next state IDLE. If rspErr=0, opCount increments (wraps 2^OPCNT_W-1 -> 0).
  - luOpCode, luA, luB stay unchanged for the whole RESP state.
- Latency: a command accepted at edge E0 gives rspValid high after E1 (after E0 for an illegal op). Minimum 3 cycles per legal op; no overlap or back-to-back acceptance.
- cmdValid may drop without a transfer; nothing is latched unless cmdReady=1.
- Once a legal op is accepted, luOpCode is one-hot or zero; it is never multi-hot.

Optional Feature:
LOGIC_SEQ_ONEHOT_CHECK_EN
- Defined:
  - In ISSUE, rspData <= the selected result only (luResultA, luResultO or luResultX per luOpCode).
  - rspErr <= 1 if either non-selected result bus is nonzero (detects a faulty or miswired logic unit).
  - An erroring response does not increment opCount.
- Undefined: the OR-combine in Behaviour applies; rspErr is set only by illegal cmdOp.

Decomposition:
- Package logic_seq_pkg:
  - op encodings: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_RSVD=2'b11
  - one-hot constants: ONEHOT_AND=3'b001, ONEHOT_OR=3'b010, ONEHOT_XOR=3'b100, ONEHOT_NONE=3'b000
  - FSM state enum
  - function op-to-one-hot
- No sub-module. The logic unit is instantiated beside the sequencer by the parent, not inside it.

Test Plan:
- Reset: assert rstN low while in RESP with rspValid=1 -> rspValid=0, luOpCode=000, opCount=0 immediately (asynchronous); after release, cmdReady=1.
- AND: cmdA=4'hC, cmdB=4'hA -> luOpCode=001 during ISSUE; rspValid rises 2 edges after accept; rspData=4'h8, rspErr=0; opCount 0->1 on transfer.
- XOR backpressure: cmdA=4'hF, cmdB=4'h5, rspReady low for 4 cycles -> rspData=4'hA held stable, cmdReady=0 throughout; opCount increments only on the transfer edge.
- Illegal op: cmdOp=11 -> rspValid after 1 edge, rspData=0, rspErr=1, luOpCode stays 000, opCount unchanged.
- Counter wrap: 256 consecutive OR ops (cmdA=4'h3, cmdB=4'h4 -> rspData=4'h7 each) -> opCount goes 8'hFF -> 8'h00.
- With LOGIC_SEQ_ONEHOT_CHECK_EN: AND op with luResultX forced to 4'h1 -> rspErr=1, rspData=AND result, opCount unchanged.
